lsu_mem_master: RTL and testbench

- Load/store initiator that drives the word-wide data_mem port (Run, MemWr, Addr, data_input, data_output) on behalf of the single-cycle core's load/store path.
- Accepts byte, halfword and word requests through a valid/ready handshake.
- Sub-word stores are performed as read-modify-write: read the word, merge the lanes, write it back.
- Sub-word loads are extracted from the word and zero- or sign-extended.
- Misaligned, out-of-range and illegal-size requests return an error response and never touch memory.

---
 rtl/lsu_mem_master_if.sv | 32 +++
 rtl/lsu_mem_master.sv | 174 +++++++++++++++++
 tb/tb_lsu_mem_master.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_master_if.sv
// Request/response and data_mem bus bundle for the load/store memory master.
// Handshake: a request transfers on a rising Clk edge where req_valid and req_ready are both high;
// rsp_valid is a single-cycle pulse with no backpressure.
interface lsu_mem_master_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              MemRun;
    logic              MemWr;
    logic [ADDR_W-1:0] MemAddr;
    logic [31:0]       MemDataIn;
    logic [31:0]       MemDataOut;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, MemDataOut,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, MemRun, MemWr, MemAddr, MemDataIn
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, MemDataOut,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, MemRun, MemWr, MemAddr, MemDataIn
    );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store initiator for a word-wide data_mem: byte/half/word access, sub-word stores as
// read-modify-write, sign/zero-extended sub-word loads, error response for illegal requests.
module lsu_mem_master #(
    parameter int MEM_BYTES = 128,
    parameter int ADDR_W    = 32
) (
    input  logic               Clk,
    input  logic               Rst_n,
    lsu_mem_master_if.slave    bus,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            state;
    logic              rdy;
    logic              mem_run;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic              rsp_valid;
    logic              rsp_err;
    logic [31:0]       rsp_rdata;

    logic              l_we;
    logic              l_signed;
    logic [1:0]        l_size;
    logic [1:0]        l_off;
    logic [31:0]       l_wdata;

    logic              acc_err;

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] size, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (size)
            2'b00:   extract = {{24{sgn & b[7]}}, b};
            2'b01:   extract = {{16{sgn & h[15]}}, h};
            default: extract = w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] off,
                                          input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] m;
        m = w;
        case (size)
            2'b00: begin
                case (off)
                    2'd0:    m[7:0]   = wd[7:0];
                    2'd1:    m[15:8]  = wd[7:0];
                    2'd2:    m[23:16] = wd[7:0];
                    default: m[31:24] = wd[7:0];
                endcase
            end
            2'b01: begin
                if (off[1]) m[31:16] = wd[15:0];
                else        m[15:0]  = wd[15:0];
            end
            default: m = wd;
        endcase
        merge = m;
    endfunction

    // Anything not naturally aligned, outside memory or of size 11 is rejected without a memory cycle.
    always_comb begin
        acc_err = (bus.req_size == 2'b11)
                | ((bus.req_size == 2'b01) & bus.req_addr[0])
                | ((bus.req_size == 2'b10) & (bus.req_addr[1:0] != 2'b00))
                | (bus.req_addr >= ADDR_W'(MEM_BYTES));
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            rdy       <= 1'b0;
            mem_run   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            l_we      <= 1'b0;
            l_signed  <= 1'b0;
            l_size    <= '0;
            l_off     <= '0;
            l_wdata   <= '0;
        end else begin
            mem_run <= 1'b1;
            case (state)
                IDLE: begin
                    if (rdy && bus.req_valid) begin
                        rdy      <= 1'b0;
                        l_we     <= bus.req_we;
                        l_signed <= bus.req_signed;
                        l_size   <= bus.req_size;
                        l_off    <= bus.req_addr[1:0];
                        l_wdata  <= bus.req_wdata;
                        if (acc_err) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (!bus.req_we || (bus.req_size != 2'b10)) begin
                            state    <= RD;
                            mem_addr <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                        end else begin
                            state    <= WR;
                            mem_addr <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                            mem_wr   <= 1'b1;
                            mem_din  <= bus.req_wdata;
                        end
                    end else begin
                        rdy <= 1'b1;
                    end
                end
                RD: begin
                    if (!l_we) begin
                        state     <= RESP;
                        mem_addr  <= '0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= extract(bus.MemDataOut, l_off, l_size, l_signed);
                    end else begin
                        state   <= WR;
                        mem_wr  <= 1'b1;
                        mem_din <= merge(bus.MemDataOut, l_off, l_size, l_wdata);
                    end
                end
                WR: begin
                    state     <= RESP;
                    mem_wr    <= 1'b0;
                    mem_addr  <= '0;
                    mem_din   <= '0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
                default: begin
                    state     <= IDLE;
                    rdy       <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
            endcase
        end
    end

    assign bus.req_ready = rdy;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_err   = rsp_err;
    assign bus.rsp_rdata = rsp_rdata;
    assign bus.MemRun    = mem_run;
    assign bus.MemWr     = mem_wr;
    assign bus.MemAddr   = mem_addr;
    assign bus.MemDataIn = mem_din;
    assign dbg_state     = state;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: data_mem model, directed vector table, held-valid and mid-RMW
// reset sequences, and random traffic scored against a byte-array reference.
module tb_lsu_mem_master;

    localparam int MEM_BYTES = 128;
    localparam int ADDR_W    = 32;

    logic       Clk   = 1'b0;
    logic       Rst_n = 1'b0;
    logic [1:0] dbg_state;

    always #5 Clk = ~Clk;

    lsu_mem_master_if #(.ADDR_W(ADDR_W)) ifc ();

    lsu_mem_master #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .bus       (ifc),
        .dbg_state (dbg_state)
    );

    // data_mem: combinational read, write on the rising edge when Run and Wr are high.
    logic [31:0] mem [32] = '{default: 32'h0};
    assign ifc.MemDataOut = (ifc.MemAddr < 32'(MEM_BYTES)) ? mem[ifc.MemAddr[6:2]] : 32'h0;
    always @(posedge Clk) begin
        if (ifc.MemRun && ifc.MemWr && (ifc.MemAddr < 32'(MEM_BYTES)))
            mem[ifc.MemAddr[6:2]] <= ifc.MemDataIn;
    end

    logic [7:0]  ref_mem [MEM_BYTES] = '{default: 8'h0};
    logic [32:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    int          acc_cnt = 0;
    bit          acc_prev = 1'b0;
    logic [31:0] last_wr_addr = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference: byte-addressed memory, access size 1<<size, natural alignment required.
    function automatic logic [32:0] model(input logic we, input logic [1:0] size, input logic sgn,
                                          input logic [31:0] addr, input logic [31:0] wdata);
        int          nb;
        logic [31:0] v;
        logic [31:0] mask;
        nb = 1 << size;
        if (size == 2'b11 || (addr % nb) != 0 || addr >= MEM_BYTES) return {1'b1, 32'h0};
        if (we) begin
            for (int i = 0; i < nb; i++) ref_mem[addr + i] = wdata[8*i +: 8];
            return {1'b0, 32'h0};
        end
        v = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[addr + i];
        mask = (nb == 1) ? 32'hFF : (nb == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
        if (sgn && nb < 4 && v[8*nb-1]) v = v | ~mask;
        return {1'b0, v};
    endfunction

    always @(posedge Clk) begin
        acc_prev = ifc.req_valid && ifc.req_ready;
        if (acc_prev) acc_cnt++;
    end

    always @(negedge Clk) begin
        logic [32:0] e;
        if (ifc.MemWr) begin
            wr_cnt++;
            last_wr_addr = ifc.MemAddr;
            check("wr_addr_aligned", ifc.MemAddr[1:0], 2'b00);
        end
        if (acc_prev) check("ready_after_accept", ifc.req_ready, 1'b0);
        if (ifc.rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("scoreboard_rsp", {ifc.rsp_err, ifc.rsp_rdata}, e);
            end
        end
    end

    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit use_model,
                         output int exp_lat, output logic [32:0] exp);
        int n;
        n = 0;
        @(negedge Clk);
        ifc.req_valid  = 1'b1;
        ifc.req_we     = we;
        ifc.req_size   = size;
        ifc.req_signed = sgn;
        ifc.req_addr   = addr;
        ifc.req_wdata  = wdata;
        while (!ifc.req_ready && n < 50) begin
            @(negedge Clk);
            n++;
        end
        check("ready_wait", ifc.req_ready, 1'b1);
        exp = '0;
        if (use_model) begin
            exp = model(we, size, sgn, addr, wdata);
            exp_q.push_back(exp);
        end
        exp_lat = exp[32] ? 1 : (!we ? 2 : (size == 2'b10 ? 2 : 3));
        @(posedge Clk);
        #1;
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic got_err, output logic [31:0] got_rdata);
        int          exp_lat;
        int          lat;
        int          w0;
        bit          seen;
        logic [32:0] e;
        issue(we, size, sgn, addr, wdata, 1'b1, exp_lat, e);
        ifc.req_valid = 1'b0;
        w0 = wr_cnt;
        seen = 1'b0;
        lat = 0;
        got_err = 1'b0;
        got_rdata = '0;
        while (!seen && lat < 20) begin
            @(negedge Clk);
            lat++;
            if (ifc.rsp_valid) begin
                seen = 1'b1;
                got_err = ifc.rsp_err;
                got_rdata = ifc.rsp_rdata;
            end
        end
        check("rsp_seen", seen, 1'b1);
        check("latency", lat, exp_lat);
        check("write_count", wr_cnt - w0, (we && !e[32]) ? 1 : 0);
        if (we && !e[32]) check("write_addr", last_wr_addr, {addr[31:2], 2'b00});
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    initial begin
        logic        ge;
        logic [31:0] gr;
        logic [32:0] e;
        int          lat;
        int          a0;
        int          w0;
        int          n;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;

        tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h0000_0987, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,         1'b0, 32'h0000_0987};
        tbl[2]  = '{1'b1, 2'd2, 1'b0, 32'h04, 32'h1122_3344, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 2'd0, 1'b0, 32'h06, 32'h0000_00AB, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 2'd2, 1'b0, 32'h04, 32'h0,         1'b0, 32'h11AB_3344};
        tbl[5]  = '{1'b0, 2'd0, 1'b1, 32'h06, 32'h0,         1'b0, 32'hFFFF_FFAB};
        tbl[6]  = '{1'b0, 2'd0, 1'b0, 32'h06, 32'h0,         1'b0, 32'h0000_00AB};
        tbl[7]  = '{1'b1, 2'd1, 1'b0, 32'h0A, 32'h0000_8001, 1'b0, 32'h0};
        tbl[8]  = '{1'b0, 2'd2, 1'b0, 32'h08, 32'h0,         1'b0, 32'h8001_0000};
        tbl[9]  = '{1'b0, 2'd1, 1'b1, 32'h0A, 32'h0,         1'b0, 32'hFFFF_8001};
        tbl[10] = '{1'b0, 2'd1, 1'b0, 32'h0A, 32'h0,         1'b0, 32'h0000_8001};
        tbl[11] = '{1'b0, 2'd2, 1'b0, 32'h02, 32'h0,         1'b1, 32'h0};
        tbl[12] = '{1'b0, 2'd1, 1'b0, 32'h03, 32'h0,         1'b1, 32'h0};
        tbl[13] = '{1'b0, 2'd3, 1'b0, 32'h00, 32'h0,         1'b1, 32'h0};
        tbl[14] = '{1'b1, 2'd3, 1'b0, 32'h08, 32'hFFFF_FFFF, 1'b1, 32'h0};
        tbl[15] = '{1'b0, 2'd2, 1'b0, 32'h80, 32'h0,         1'b1, 32'h0};
        tbl[16] = '{1'b1, 2'd0, 1'b0, 32'h80, 32'h0000_0055, 1'b1, 32'h0};
        tbl[17] = '{1'b1, 2'd2, 1'b0, 32'h7C, 32'hDEAD_BEEF, 1'b0, 32'h0};
        tbl[18] = '{1'b0, 2'd2, 1'b0, 32'h7C, 32'h0,         1'b0, 32'hDEAD_BEEF};
        tbl[19] = '{1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h0,  1'b1, 32'h0};
        tbl[20] = '{1'b0, 2'd2, 1'b0, 32'h08, 32'h0,         1'b0, 32'h8001_0000};
        tbl[21] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,         1'b0, 32'h0000_0987};
        tbl[22] = '{1'b0, 2'd2, 1'b1, 32'h7C, 32'h0,         1'b0, 32'hDEAD_BEEF};

        ifc.req_valid  = 1'b0;
        ifc.req_we     = 1'b0;
        ifc.req_size   = 2'b00;
        ifc.req_signed = 1'b0;
        ifc.req_addr   = '0;
        ifc.req_wdata  = '0;

        // Reset state
        repeat (3) @(negedge Clk);
        check("rst_req_ready", ifc.req_ready, 1'b0);
        check("rst_MemRun",    ifc.MemRun,    1'b0);
        check("rst_MemWr",     ifc.MemWr,     1'b0);
        check("rst_MemAddr",   ifc.MemAddr,   32'h0);
        check("rst_MemDataIn", ifc.MemDataIn, 32'h0);
        check("rst_rsp_valid", ifc.rsp_valid, 1'b0);
        check("rst_rsp_rdata", ifc.rsp_rdata, 32'h0);
        check("rst_rsp_err",   ifc.rsp_err,   1'b0);
        Rst_n = 1'b1;
        @(negedge Clk);
        check("run_after_rst",   ifc.MemRun,    1'b1);
        check("ready_after_rst", ifc.req_ready, 1'b1);

        // Directed vectors
        for (int i = 0; i < NV; i++) begin
            do_req(tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, ge, gr);
            check($sformatf("vec%0d_err", i), ge, tbl[i].exp_err);
            check($sformatf("vec%0d_rdata", i), gr, tbl[i].exp_rdata);
        end

        // Four requests with req_valid held high throughout
        a0 = acc_cnt;
        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'hA5A5_0001, 1'b1, lat, e);
        issue(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_0077, 1'b1, lat, e);
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0,         1'b1, lat, e);
        issue(1'b0, 2'd1, 1'b0, 32'h03, 32'h0,         1'b1, lat, e);
        ifc.req_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge Clk);
            n++;
        end
        check("b2b_drain", exp_q.size(), 0);
        check("b2b_accepts", acc_cnt - a0, 4);
        check("b2b_word", mem[8], 32'hA5A5_7701);

        // Reset while a byte store sits in its read cycle
        issue(1'b1, 2'd0, 1'b0, 32'h05, 32'h0000_00CC, 1'b0, lat, e);
        w0 = wr_cnt;
        Rst_n = 1'b0;
        #1;
        check("midrst_MemWr",     ifc.MemWr,     1'b0);
        check("midrst_MemRun",    ifc.MemRun,    1'b0);
        check("midrst_rsp_valid", ifc.rsp_valid, 1'b0);
        ifc.req_valid = 1'b0;
        repeat (2) @(negedge Clk);
        check("midrst_hold_rsp", ifc.rsp_valid, 1'b0);
        Rst_n = 1'b1;
        @(negedge Clk);
        check("midrst_run_back", ifc.MemRun, 1'b1);
        check("midrst_no_write", wr_cnt - w0, 0);
        check("midrst_mem", mem[1], 32'h11AB_3344);
        do_req(1'b0, 2'd2, 1'b0, 32'h04, 32'h0, ge, gr);
        check("midrst_load", gr, 32'h11AB_3344);

        // Random traffic scored against the reference model
        for (int i = 0; i < 300; i++) begin
            n = $urandom_range(0, 9);
            size = (n < 9) ? 2'(n % 3) : 2'b11;
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) addr = $urandom_range(0, MEM_BYTES + 7);
            else addr = $urandom_range(0, MEM_BYTES - 1) & ~((32'd1 << size) - 32'd1);
            do_req(we, size, 1'($urandom_range(0, 1)), addr, $urandom, ge, gr);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge Clk);
            n++;
        end
        check("final_drain", exp_q.size(), 0);
        for (int w = 0; w < MEM_BYTES / 4; w++)
            check($sformatf("mem_word%0d", w), mem[w],
                  {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
